// File: rtl/mem_arb_pkg.sv
// Shared definitions for the shared-memory round-robin arbiter.
// Holds the arbiter state encoding, the default address/data widths and the
// cache-coherency state type that the memory side and this block both use.
package mem_arb_pkg;

  localparam int DEF_ADDR_W = 14;
  localparam int DEF_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } arb_state_t;

  // Line coherency state (Invalid / Modified / Shared).
  typedef enum logic [1:0] {
    COH_I,
    COH_M,
    COH_S
  } coherency_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker.
// Scans req starting at ptr and wrapping, and returns the first set index.
//   req     : per-requester request vector
//   ptr     : index that currently has highest priority
//   winner  : index of the first set request at or after ptr (ptr when none)
//   any_req : at least one request is set
module rr_priority_picker #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [$clog2(NUM_REQ)-1:0] winner,
  output logic                       any_req
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] idx;

  // Walk the offsets from farthest to nearest so that the nearest set request
  // is the last one written and therefore wins. NUM_REQ is a power of two, so
  // the IDX_W-bit add wraps modulo NUM_REQ for free.
  always_comb begin
    idx     = '0;
    winner  = ptr;
    any_req = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = ptr + IDX_W'(i);
      if (req[idx]) begin
        winner  = idx;
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing a single-ported memory between NUM_REQ ports.
// One request is latched at a time and driven onto a single-outstanding
// memory handshake; the winner gets a one-cycle resp pulse with rdata/err.
// A hung memory is cut off after TIMEOUT_CYC ISSUE cycles with err=1.
//   clk, reset_n          : clock, synchronous active-low reset
//   req/we/addr/wdata     : per-port request, packed port i at [i*W +: W]
//   resp/err/rdata        : one-hot completion pulse, timeout flag, read data
//   grant_id, busy        : port being served, transaction in flight
//   mem_req/we/addr/wdata : memory strobe and latched request
//   mem_ack, mem_rdata    : memory completion and read data
module mem_rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ-1:0]          we,
  input  logic [NUM_REQ*ADDR_W-1:0]   addr,
  input  logic [NUM_REQ*DATA_W-1:0]   wdata,
  output logic [NUM_REQ-1:0]          resp,
  output logic                        err,
  output logic [DATA_W-1:0]           rdata,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        busy,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic                        mem_ack,
  input  logic [DATA_W-1:0]           mem_rdata
);

  localparam int               IDX_W    = $clog2(NUM_REQ);
  localparam int               CNT_W    = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  arb_state_t       state;
  arb_state_t       state_next;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] winner;
  logic             any_req;
  logic [CNT_W-1:0] wait_cnt;
  logic             timed_out;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req     (req),
    .ptr     (ptr),
    .winner  (winner),
    .any_req (any_req)
  );

  // Last ISSUE cycle the memory is allowed before we give up on it.
  assign timed_out = (wait_cnt == CNT_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and the outputs that follow directly from the state.
  // An ack in the final allowed cycle still counts as a normal completion.
  always_comb begin
    state_next = state;
    resp       = '0;
    busy       = 1'b0;
    mem_req    = 1'b0;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        if (mem_ack || timed_out) begin
          state_next = RESP;
        end
      end
      RESP: begin
        busy           = 1'b1;
        resp[grant_id] = 1'b1;
        state_next     = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Request latch, round-robin pointer, timeout counter and response data.
  // The mem_* fields are only written in IDLE so they stay frozen for the
  // whole access regardless of what the requester does with its inputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      grant_id  <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ptr       <= '0;
      wait_cnt  <= '0;
      err       <= 1'b0;
      rdata     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            grant_id  <= winner;
            mem_we    <= we[winner];
            mem_addr  <= addr[winner*ADDR_W +: ADDR_W];
            mem_wdata <= wdata[winner*DATA_W +: DATA_W];
            ptr       <= winner + 1'b1;
          end
        end
        ISSUE: begin
          if (mem_ack) begin
            err <= 1'b0;
            if (!mem_we) begin
              rdata <= mem_rdata;
            end
          end else if (timed_out) begin
            err   <= 1'b1;
            rdata <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESP: begin
          wait_cnt <= '0;
        end
        default: begin
          wait_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Self-checking bench for mem_rr_arbiter.
// The bench plays the memory (a sparse array) and the processors, and keeps a
// transaction-level model: a set of pending requests, a round-robin pointer,
// the last returned read data and the memory contents.
module tb_mem_rr_arbiter;

  localparam int N  = 4;
  localparam int AW = 14;
  localparam int DW = 16;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N-1:0]    req;
  logic [N-1:0]    we;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]    resp;
  logic            err;
  logic [DW-1:0]   rdata;
  logic [1:0]      grant_id;
  logic            busy;
  logic            mem_req;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic            mem_ack;
  logic [DW-1:0]   mem_rdata;

  int testCount = 0;
  int failCount = 0;

  bit            pending [N];
  logic          pWe     [N];
  logic [AW-1:0] pAddr   [N];
  logic [DW-1:0] pWdata  [N];
  int            modelPtr   = 0;
  logic [DW-1:0] modelRdata = '0;
  logic [DW-1:0] memModel [int];

  mem_rr_arbiter #(
    .NUM_REQ     (N),
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .resp      (resp),
    .err       (err),
    .rdata     (rdata),
    .grant_id  (grant_id),
    .busy      (busy),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Raise a request on one port and remember it in the model.
  task automatic applyStimulus(input int port, input logic w, input logic [AW-1:0] a,
                               input logic [DW-1:0] d);
    req[port]            = 1'b1;
    we[port]             = w;
    addr[port*AW +: AW]  = a;
    wdata[port*DW +: DW] = d;
    pending[port]        = 1'b1;
    pWe[port]            = w;
    pAddr[port]          = a;
    pWdata[port]         = d;
  endtask

  function automatic logic [DW-1:0] readMem(input logic [AW-1:0] a);
    return memModel.exists(int'(a)) ? memModel[int'(a)] : '0;
  endfunction

  function automatic int pickWinner();
    for (int i = 0; i < N; i++) begin
      if (pending[(modelPtr + i) % N]) return (modelPtr + i) % N;
    end
    return 0;
  endfunction

  // Run one transaction from the IDLE cycle in which requests are presented.
  // ackDelay < 0 means the memory never answers.
  task automatic serveOne(input int ackDelay, input bit dropReq);
    int            w;
    int            cyc;
    logic [DW-1:0] rd;
    logic [DW-1:0] expRdata;
    logic          expErr;
    w        = pickWinner();
    modelPtr = (w + 1) % N;
    rd       = readMem(pAddr[w]);
    @(posedge clk); #1;
    checkOutput("issue_mem_req", mem_req, 1);
    checkOutput("issue_busy", busy, 1);
    checkOutput("issue_grant_id", grant_id, w);
    checkOutput("issue_mem_we", mem_we, pWe[w]);
    checkOutput("issue_mem_addr", mem_addr, pAddr[w]);
    checkOutput("issue_mem_wdata", mem_wdata, pWdata[w]);
    addr[w*AW +: AW]  = AW'($urandom);
    wdata[w*DW +: DW] = DW'($urandom);
    if (dropReq) req[w] = 1'b0;
    if (ackDelay >= 0) begin
      for (int k = 0; k <= ackDelay; k++) begin
        mem_ack   = (k == ackDelay);
        mem_rdata = (k == ackDelay && !pWe[w]) ? rd : DW'($urandom);
        @(posedge clk); #1;
        if (k < ackDelay) begin
          checkOutput("wait_mem_req", mem_req, 1);
          checkOutput("wait_resp", resp, 0);
          checkOutput("wait_mem_addr", mem_addr, pAddr[w]);
        end
      end
      expErr   = 1'b0;
      expRdata = pWe[w] ? modelRdata : rd;
    end else begin
      mem_ack = 1'b0;
      cyc     = 0;
      do begin
        mem_rdata = DW'($urandom);
        @(posedge clk); #1;
        cyc++;
      end while (resp == '0 && cyc < TO + 4);
      checkOutput("timeout_cycles", cyc, TO);
      expErr   = 1'b1;
      expRdata = '0;
    end
    checkOutput("resp_onehot", resp, 32'(1) << w);
    checkOutput("resp_err", err, expErr);
    checkOutput("resp_rdata", rdata, expRdata);
    checkOutput("resp_mem_req", mem_req, 0);
    checkOutput("resp_grant_id", grant_id, w);
    modelRdata = expRdata;
    if (ackDelay >= 0 && pWe[w]) memModel[int'(pAddr[w])] = pWdata[w];
    pending[w] = 1'b0;
    req[w]     = 1'b0;
    mem_ack    = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    checkOutput("idle_resp", resp, 0);
    checkOutput("idle_busy", busy, 0);
  endtask

  initial begin
    reset_n   = 1'b0;
    req       = '0;
    we        = '0;
    addr      = '0;
    wdata     = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_resp", resp, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_rdata", rdata, 0);
    checkOutput("rst_grant_id", grant_id, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_mem_req", mem_req, 0);
    checkOutput("rst_mem_fields", {mem_we, mem_addr, mem_wdata}, 0);
    reset_n = 1'b1;

    // Single read from port 2, immediate ack.
    memModel[5] = 16'h0006;
    applyStimulus(2, 1'b0, 14'd5, 16'h0000);
    serveOne(0, 1'b0);

    // Write from port 1 then read back from port 3.
    applyStimulus(1, 1'b1, 14'd10, 16'hBEEF);
    serveOne(1, 1'b0);
    applyStimulus(3, 1'b0, 14'd10, 16'h0000);
    serveOne(0, 1'b0);
    checkOutput("readback_beef", rdata, 16'hBEEF);

    // All ports contending, each re-raised after its response.
    for (int k = 0; k < 5; k++) begin
      for (int p = 0; p < N; p++) begin
        if (!pending[p]) applyStimulus(p, 1'b0, AW'(p), 16'h0000);
      end
      serveOne(0, 1'b0);
    end
    for (int p = 0; p < N; p++) begin
      if (pending[p]) serveOne(0, 1'b0);
    end

    // Hung memory, then a normal access.
    applyStimulus(0, 1'b1, 14'd3, 16'h1234);
    serveOne(-1, 1'b0);
    applyStimulus(0, 1'b0, 14'd3, 16'h0000);
    serveOne(2, 1'b0);

    // Reset while a transaction is in ISSUE.
    applyStimulus(2, 1'b0, 14'd7, 16'h0000);
    @(posedge clk); #1;
    checkOutput("preRst_mem_req", mem_req, 1);
    reset_n    = 1'b0;
    req        = '0;
    pending[2] = 1'b0;
    @(posedge clk); #1;
    checkOutput("midRst_mem_req", mem_req, 0);
    checkOutput("midRst_resp", resp, 0);
    checkOutput("midRst_busy", busy, 0);
    reset_n    = 1'b1;
    modelPtr   = 0;
    modelRdata = '0;
    applyStimulus(1, 1'b0, 14'd1, 16'h0000);
    applyStimulus(3, 1'b0, 14'd2, 16'h0000);
    serveOne(0, 1'b0);
    serveOne(0, 1'b0);

    // Pointer wrap: serve port 2 so port 3 is next in line.
    applyStimulus(2, 1'b0, 14'd4, 16'h0000);
    serveOne(0, 1'b0);
    applyStimulus(0, 1'b0, 14'd5, 16'h0000);
    applyStimulus(3, 1'b0, 14'd6, 16'h0000);
    serveOne(0, 1'b0);
    serveOne(0, 1'b0);

    // Stray ack while nothing is requested.
    mem_ack   = 1'b1;
    mem_rdata = 16'hDEAD;
    repeat (3) begin
      @(posedge clk); #1;
      checkOutput("stale_busy", busy, 0);
      checkOutput("stale_resp", resp, 0);
      checkOutput("stale_rdata", rdata, modelRdata);
    end
    mem_ack = 1'b0;

    // Random traffic.
    repeat (200) begin
      for (int p = 0; p < N; p++) begin
        if (!pending[p] && $urandom_range(0, 1) == 1)
          applyStimulus(p, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom));
      end
      if (!(pending[0] || pending[1] || pending[2] || pending[3]))
        applyStimulus($urandom_range(0, N - 1), 1'b0, AW'($urandom_range(0, 15)), 16'h0000);
      serveOne(($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 4)),
               1'($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
